ram_stream_reader: RTL and testbench

- Read-side initiator for the on-chip dual-port block RAM (S-box / key-schedule storage), driving one RAM port.
- On a start command, reads LEN consecutive words beginning at BASE and presents them on a valid/ready output stream, with TLAST on the final word.
- The RAM returns data one cycle after the address (registered output, no read enable).
- A 2-entry skid buffer absorbs that latency so output backpressure never loses a word.

---
 rtl/ram_stream_reader_pkg.sv | 13 +
 rtl/ram_rd_skid.sv | 55 +++++
 rtl/ram_stream_reader.sv | 145 ++++++++++++++
 tb/tb_ram_stream_reader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the RAM stream reader and its skid buffer.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int RAM_RD_LAT = 1;

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry skid buffer holding RAM read words plus their last flag; entry 0 is the head.
module ram_rd_skid #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic [1:0]        occ
);

  logic [DATA_W:0] ent0;
  logic [DATA_W:0] ent1;
  logic [DATA_W:0] din;

  assign din       = {push_last, push_data};
  assign head_data = ent0[DATA_W-1:0];
  assign head_last = ent0[DATA_W];

  // Pop is only ever asserted with occ > 0, and the issuer never lets push hit a full buffer
  // unless a pop frees a slot in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) ent0 <= din;
          else             ent1 <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            ent0 <= ent1;
            ent1 <= din;
          end else begin
            ent0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads LEN consecutive RAM words from BASE and streams them out with valid/ready and last.
// Optional macro RAM_STREAM_READER_BSWAP_EN byte-reverses each streamed word.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  if (RAM_RD_LAT != 1) begin : g_bad_lat
    $error("ram_stream_reader tracks exactly one cycle of RAM read latency");
  end

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   issued;
  logic                  vld_p1, last_p1;
  logic                  accept, issue, done_nx, pop, credit_ok;
  logic [1:0]            occ;
  logic [2:0]            outstanding;
  logic                  head_last;
  logic [DATA_WIDTH-1:0] head_data;

  assign ram_we  = 1'b0;
  assign m_valid = (occ != 2'd0);
  assign m_last  = head_last;
  assign pop     = m_valid & m_ready;

  // A pop this cycle frees a slot before the new read lands, which keeps full throughput.
  assign outstanding = {1'b0, occ} + {2'b00, vld_p1};
  assign credit_ok   = outstanding < (3'(SKID_DEPTH) + {2'b00, pop});

  // Stage p0: the address goes to the RAM combinationally in the issue cycle.
  assign ram_addr = accept ? base : rd_addr;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    issue    = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_nx = 1'b1;
          end else begin
            accept   = 1'b1;
            issue    = 1'b1;
            state_nx = READ;
          end
        end
      end
      READ: begin
        if (issued == len_q) state_nx = DRAIN;
        else if (credit_ok)  issue    = 1'b1;
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_addr <= '0;
      len_q   <= '0;
      issued  <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      state  <= state_nx;
      busy   <= (state_nx != IDLE);
      done   <= done_nx;
      vld_p1 <= issue;
      if (accept) begin
        len_q   <= len;
        rd_addr <= base + 1'b1;
        issued  <= CNT_ONE;
        last_p1 <= (len == CNT_ONE);
      end else if (issue) begin
        rd_addr <= rd_addr + 1'b1;
        issued  <= issued + CNT_ONE;
        last_p1 <= ((issued + CNT_ONE) == len_q);
      end
    end
  end

  // Stage p1: RAM data is valid here and is captured only when flagged by vld_p1.
  ram_rd_skid #(
    .DATA_W (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_p1),
    .push_data (ram_dout),
    .push_last (last_p1),
    .pop       (pop),
    .head_data (head_data),
    .head_last (head_last),
    .occ       (occ)
  );

`ifdef RAM_STREAM_READER_BSWAP_EN
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8 when byte swapping is enabled");
  end

  function automatic logic [DATA_WIDTH-1:0] bswap(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_WIDTH / 8; i++) r[8*i +: 8] = d[DATA_WIDTH-8-8*i +: 8];
    return r;
  endfunction

  assign m_data = bswap(head_data);
`else
  assign m_data = head_data;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural one-cycle-latency RAM.
module tb_ram_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base;
  logic [10:0] len;
  logic        busy, done, ram_we, m_valid, m_ready, m_last;
  logic [9:0]  ram_addr;
  logic [31:0] ram_dout, m_data;
  logic [31:0] mem [0:1023];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_stream_reader #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_dout (ram_dout),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last)
  );

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = (i == 0) ? 32'h11223344 : 32'(i * 3);
  end

  always @(posedge clk) ram_dout <= mem[ram_addr];

  function automatic logic [31:0] model(input int a);
    int aa;
    logic [31:0] w;
    aa = a % 1024;
    w  = (aa == 0) ? 32'h11223344 : 32'(aa * 3);
`ifdef RAM_STREAM_READER_BSWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int b, input int n);
    base  = 10'(b);
    len   = 11'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Consumes one command's stream using a repeating 6-cycle ready pattern, then checks done.
  task automatic collect(input string tag, input int b, input int n, input logic [5:0] pat);
    int idx = 0;
    int cyc = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [31:0] pd = '0;
    while (idx < n && cyc < 200) begin
      m_ready = pat[cyc % 6];
      if (pv && !pr) begin
        chk1($sformatf("%s hold_valid", tag), m_valid, 1'b1);
        chkw($sformatf("%s hold_data", tag), m_data, pd);
      end
      if (m_valid) begin
        chkw($sformatf("%s data[%0d]", tag, idx), m_data, model(b + idx));
        chk1($sformatf("%s last[%0d]", tag, idx), m_last, idx == n - 1);
        if (m_ready) idx++;
      end
      pv = m_valid;
      pr = m_ready;
      pd = m_data;
      tick();
      cyc++;
    end
    chkw($sformatf("%s words", tag), 32'(idx), 32'(n));
    chk1($sformatf("%s done", tag), done, 1'b1);
    chk1($sformatf("%s busy_low", tag), busy, 1'b0);
    chk1($sformatf("%s valid_low", tag), m_valid, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, " busy"}, busy, 1'b0);
    chk1({tag, " done"}, done, 1'b0);
    chkw({tag, " ram_addr"}, 32'(ram_addr), 32'd0);
    chk1({tag, " ram_we"}, ram_we, 1'b0);
    chkw({tag, " m_data"}, m_data, 32'd0);
    chk1({tag, " m_valid"}, m_valid, 1'b0);
    chk1({tag, " m_last"}, m_last, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base = '0; len = '0; m_ready = 1'b0;
    tick();
    chk_reset_outputs("reset");
    tick();
    rst = 1'b0;
    tick();

    // Latency and throughput: base=4, len=5 -> 12,15,18,21,24.
    m_ready = 1'b1;
    pulse_start(4, 5);
    chk1("t1 busy", busy, 1'b1);
    chk1("t1 valid_c1", m_valid, 1'b0);
    tick();
    chk1("t1 valid_c2", m_valid, 1'b1);
    chkw("t1 w0", m_data, model(4));
    chk1("t1 last0", m_last, 1'b0);
    for (int k = 1; k < 5; k++) begin
      tick();
      chk1($sformatf("t1 valid%0d", k), m_valid, 1'b1);
      chkw($sformatf("t1 w%0d", k), m_data, model(4 + k));
      chk1($sformatf("t1 last%0d", k), m_last, k == 4);
    end
    tick();
    chk1("t1 done", done, 1'b1);
    chk1("t1 busy_low", busy, 1'b0);
    chk1("t1 valid_low", m_valid, 1'b0);
    tick();
    chk1("t1 done_once", done, 1'b0);

    // Address wrap.
    pulse_start(1022, 4);
    collect("wrap", 1022, 4, 6'b111111);
    tick();

    // Backpressure 1,0,0,1,0,1.
    pulse_start(30, 6);
    collect("bp", 30, 6, 6'b101001);
    tick();

    // Zero-length command.
    pulse_start(7, 0);
    chk1("z done", done, 1'b1);
    chk1("z busy", busy, 1'b0);
    chk1("z valid", m_valid, 1'b0);
    tick();
    chk1("z done_once", done, 1'b0);
    chk1("z busy2", busy, 1'b0);

    // Start while busy is ignored.
    m_ready = 1'b0;
    pulse_start(10, 3);
    pulse_start(100, 2);
    collect("ign", 10, 3, 6'b111111);
    tick();
    chk1("ign no_queue_valid", m_valid, 1'b0);
    chk1("ign no_queue_busy", busy, 1'b0);

    // Asynchronous reset after two handshakes of an 8-word command.
    m_ready = 1'b1;
    pulse_start(20, 8);
    tick();
    chkw("rst w0", m_data, model(20));
    tick();
    tick();
    chkw("rst w2", m_data, model(22));
    #2 rst = 1'b1;
    #1 chk_reset_outputs("async_rst");
    tick();
    rst = 1'b0;
    tick();
    chk1("rst no_done", done, 1'b0);
    pulse_start(0, 3);
    collect("post_rst", 0, 3, 6'b111111);
`ifdef RAM_STREAM_READER_BSWAP_EN
    chkw("bswap model", model(0), 32'h44332211);
`else
    chkw("plain model", model(0), 32'h11223344);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
